// File: rtl/clahe_div_arbiter.sv
// Round-robin front end that time-shares one pipelined divider between NUM_REQ
// requesters. Optional divide-by-zero guard: define CLAHE_DIV_ZERO_GUARD_EN.
module clahe_div_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int DIV_LATENCY = 33,
  parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_dividend,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_divisor,
  output logic                                div_start,
  output logic [DATA_WIDTH-1:0]               div_dividend,
  output logic [DATA_WIDTH-1:0]               div_divisor,
  input  logic                                div_done,
  input  logic [DATA_WIDTH-1:0]               div_quotient,
  input  logic [DATA_WIDTH-1:0]               div_remainder,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [ID_W-1:0]                     rsp_id,
  output logic [DATA_WIDTH-1:0]               rsp_quotient,
  output logic [DATA_WIDTH-1:0]               rsp_remainder,
  output logic                                rsp_dz,
  output logic [$clog2(DIV_LATENCY+1)-1:0]    inflight,
  output logic                                err_desync
);

  localparam int CNT_W = $clog2(DIV_LATENCY + 1);

  logic [ID_W-1:0]                    ptr_q, ptr_d;
  logic [ID_W-1:0]                    gnt_id_s;
  logic [ID_W-1:0]                    idx_s;
  logic                               found_s;
  logic                               issue_s;
  logic [NUM_REQ-1:0]                 ready_s;
  logic [DATA_WIDTH-1:0]              sel_dividend_s;
  logic [DATA_WIDTH-1:0]              sel_divisor_s;

  logic [DIV_LATENCY-1:0]             tag_vld_q, tag_vld_d;
  logic [DIV_LATENCY-1:0][ID_W-1:0]   tag_id_q, tag_id_d;
  logic                               retire_vld_s;
  logic [ID_W-1:0]                    retire_id_s;

  logic [NUM_REQ-1:0]                 rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]                    rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0]              rsp_quot_q, rsp_quot_d;
  logic [DATA_WIDTH-1:0]              rsp_rem_q, rsp_rem_d;
  logic                               err_desync_q, err_desync_d;
  logic [CNT_W-1:0]                   inflight_q, inflight_d;

`ifdef CLAHE_DIV_ZERO_GUARD_EN
  logic [DIV_LATENCY-1:0]             tag_dz_q, tag_dz_d;
  logic                               retire_dz_s;
  logic                               rsp_dz_q, rsp_dz_d;
`endif

  // Search from ptr_q, wrapping, for the first valid requester.
  always_comb begin
    found_s  = 1'b0;
    gnt_id_s = '0;
    idx_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found_s && req_valid[idx_s]) begin
        found_s  = 1'b1;
        gnt_id_s = idx_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Grant, operand mux and pointer update; grants are suppressed while in reset.
  always_comb begin
    issue_s        = found_s & rst_n;
    ready_s        = '0;
    sel_dividend_s = '0;
    sel_divisor_s  = '0;
    ptr_d          = ptr_q;
    if (issue_s) begin
      ready_s[gnt_id_s] = 1'b1;
      sel_dividend_s    = req_dividend[int'(gnt_id_s)*DATA_WIDTH +: DATA_WIDTH];
      sel_divisor_s     = req_divisor[int'(gnt_id_s)*DATA_WIDTH +: DATA_WIDTH];
      ptr_d             = (gnt_id_s == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_s + ID_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  assign req_ready    = ready_s;
  assign div_start    = issue_s;
  assign div_dividend = sel_dividend_s;
  assign div_divisor  = sel_divisor_s;

  // Tag shift register: stage 0 loads at the divider's sampling edge.
  always_comb begin
    tag_vld_d = {tag_vld_q[DIV_LATENCY-2:0], issue_s};
    tag_id_d  = {tag_id_q[DIV_LATENCY-2:0], gnt_id_s};
`ifdef CLAHE_DIV_ZERO_GUARD_EN
    tag_dz_d  = {tag_dz_q[DIV_LATENCY-2:0], issue_s & (sel_divisor_s == '0)};
`endif
  end

  assign retire_vld_s = tag_vld_q[DIV_LATENCY-1];
  assign retire_id_s  = tag_id_q[DIV_LATENCY-1];
`ifdef CLAHE_DIV_ZERO_GUARD_EN
  assign retire_dz_s  = tag_dz_q[DIV_LATENCY-1];
`endif

  // Response steering; a done/tag mismatch suppresses the strobe and latches the error.
  always_comb begin
    rsp_valid_d  = '0;
    rsp_id_d     = rsp_id_q;
    rsp_quot_d   = rsp_quot_q;
    rsp_rem_d    = rsp_rem_q;
`ifdef CLAHE_DIV_ZERO_GUARD_EN
    rsp_dz_d     = rsp_dz_q;
`endif
    err_desync_d = err_desync_q | (div_done ^ retire_vld_s);
    if (div_done && retire_vld_s) begin
      rsp_valid_d[retire_id_s] = 1'b1;
      rsp_id_d                 = retire_id_s;
      rsp_quot_d               = div_quotient;
      rsp_rem_d                = div_remainder;
`ifdef CLAHE_DIV_ZERO_GUARD_EN
      rsp_dz_d                 = retire_dz_s;
      if (retire_dz_s) begin
        rsp_quot_d = {DATA_WIDTH{1'b1}};
        rsp_rem_d  = '0;
      end else begin
        rsp_quot_d = div_quotient;
      end
`endif
    end else begin
      rsp_valid_d = '0;
    end
  end

  // Occupancy tracks the number of valid tags in the shift register.
  always_comb begin
    case ({issue_s, retire_vld_s})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_id_q     <= '0;
      rsp_quot_q   <= '0;
      rsp_rem_q    <= '0;
      err_desync_q <= 1'b0;
      inflight_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_quot_q   <= rsp_quot_d;
      rsp_rem_q    <= rsp_rem_d;
      err_desync_q <= err_desync_d;
      inflight_q   <= inflight_d;
    end
  end

`ifdef CLAHE_DIV_ZERO_GUARD_EN
  // Divide-by-zero tag bits and the registered flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_dz_q <= '0;
      rsp_dz_q <= 1'b0;
    end else begin
      tag_dz_q <= tag_dz_d;
      rsp_dz_q <= rsp_dz_d;
    end
  end

  assign rsp_dz = rsp_dz_q;
`else
  assign rsp_dz = 1'b0;
`endif

  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_quotient  = rsp_quot_q;
  assign rsp_remainder = rsp_rem_q;
  assign inflight      = inflight_q;
  assign err_desync    = err_desync_q;

endmodule

// File: tb/tb_clahe_div_arbiter.sv
// Directed bench for clahe_div_arbiter with a behavioural fixed-latency divider.
module tb_clahe_div_arbiter;

  localparam int NR  = 2;
  localparam int DW  = 32;
  localparam int LAT = 33;
  localparam int IW  = 1;
  localparam int CW  = $clog2(LAT + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_dividend;
  logic [NR*DW-1:0]  req_divisor;
  logic              div_start;
  logic [DW-1:0]     div_dividend;
  logic [DW-1:0]     div_divisor;
  logic              div_done;
  logic [DW-1:0]     div_quotient;
  logic [DW-1:0]     div_remainder;
  logic [NR-1:0]     rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_quotient;
  logic [DW-1:0]     rsp_remainder;
  logic              rsp_dz;
  logic [CW-1:0]     inflight;
  logic              err_desync;
  logic              inj_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  clahe_div_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .DIV_LATENCY(LAT), .ID_W(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_dz(rsp_dz),
    .inflight(inflight), .err_desync(err_desync)
  );

  // Behavioural divider: LAT register stages, flushed by the shared reset.
  logic          m_v [LAT];
  logic [DW-1:0] m_q [LAT];
  logic [DW-1:0] m_r [LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) begin
        m_v[s] <= 1'b0;
        m_q[s] <= '0;
        m_r[s] <= '0;
      end
    end else begin
      m_v[0] <= div_start;
      m_q[0] <= (div_divisor == '0) ? '1 : div_dividend / div_divisor;
      m_r[0] <= (div_divisor == '0) ? div_dividend : div_dividend % div_divisor;
      for (int s = 1; s < LAT; s++) begin
        m_v[s] <= m_v[s-1];
        m_q[s] <= m_q[s-1];
        m_r[s] <= m_r[s-1];
      end
    end
  end

  assign div_done      = m_v[LAT-1] | inj_done;
  assign div_quotient  = m_q[LAT-1];
  assign div_remainder = m_r[LAT-1];

  typedef struct {
    logic [NR-1:0] vld;
    logic [IW-1:0] id;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dz;
    int            cyc;
  } rsp_t;

  rsp_t rq[$];
  rsp_t cap_e;

  always @(posedge clk) cyc++;

  // Record every response strobe with its cycle stamp.
  always @(negedge clk) begin
    if (rsp_valid != '0) begin
      cap_e.vld = rsp_valid;
      cap_e.id  = rsp_id;
      cap_e.q   = rsp_quotient;
      cap_e.r   = rsp_remainder;
      cap_e.dz  = rsp_dz;
      cap_e.cyc = cyc;
      rq.push_back(cap_e);
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rq.delete();
  endtask

  int a0 [5] = '{100, 250, 999, 64, 0};
  int b0 [5] = '{3, 7, 10, 8, 1};
  int q0 [4] = '{33, 35, 99, 8};
  int r0 [4] = '{1, 5, 9, 0};
  int a1 [5] = '{77, 1000, 12345, 7, 0};
  int b1 [5] = '{5, 33, 100, 9, 1};
  int q1 [4] = '{15, 30, 123, 0};
  int r1 [4] = '{2, 10, 45, 7};

  initial begin
    rst_n        = 1'b0;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    inj_done     = 1'b0;

    // Reset state, with requests pending to show that grants are held off.
    repeat (2) @(negedge clk);
    req_valid    = 2'b11;
    req_dividend = {32'd5, 32'd9};
    req_divisor  = {32'd1, 32'd1};
    #1;
    check_val("rst_ready", req_ready, 2'b00);
    check_val("rst_start", div_start, 1'b0);
    check_val("rst_dvd", div_dividend, 32'd0);
    check_val("rst_rspv", rsp_valid, 2'b00);
    check_val("rst_infl", inflight, 6'd0);
    check_val("rst_err", err_desync, 1'b0);
    check_val("rst_quot", rsp_quotient, 32'd0);
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;

    // Single op 100/7 from requester 0.
    @(negedge clk);
    rq.delete();
    req_valid             = 2'b01;
    req_dividend[0 +: DW] = 32'd100;
    req_divisor[0 +: DW]  = 32'd7;
    #1;
    check_val("t1_ready", req_ready, 2'b01);
    check_val("t1_start", div_start, 1'b1);
    check_val("t1_dvd", div_dividend, 32'd100);
    check_val("t1_dvs", div_divisor, 32'd7);
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        req_valid = '0;
        check_val("t1_infl1", inflight, 6'd1);
      end
      if (k == 33) check_val("t1_early", rsp_valid, 2'b00);
    end
    check_val("t1_rspv", rsp_valid, 2'b01);
    check_val("t1_id", rsp_id, 1'b0);
    check_val("t1_quot", rsp_quotient, 32'd14);
    check_val("t1_rem", rsp_remainder, 32'd2);
    check_val("t1_infl0", inflight, 6'd0);
    @(negedge clk);
    check_val("t1_strobe", rsp_valid, 2'b00);
    check_val("t1_hold", rsp_quotient, 32'd14);

    // Both requesters valid for 8 cycles: grants alternate from 0.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req_valid              = 2'b11;
      req_dividend[0 +: DW]  = a0[(i + 1) / 2];
      req_divisor[0 +: DW]   = b0[(i + 1) / 2];
      req_dividend[DW +: DW] = a1[i / 2];
      req_divisor[DW +: DW]  = b1[i / 2];
      #1;
      check_val($sformatf("t2_gnt%0d", i), req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
    end
    req_valid = '0;
    repeat (40) @(negedge clk);
    check_val("t2_count", rq.size(), 8);
    if (rq.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check_val($sformatf("t2_id%0d", i), rq[i].id, i % 2);
        check_val($sformatf("t2_vld%0d", i), rq[i].vld, (i % 2 == 0) ? 2'b01 : 2'b10);
        check_val($sformatf("t2_q%0d", i), rq[i].q, (i % 2 == 0) ? q0[i / 2] : q1[i / 2]);
        check_val($sformatf("t2_r%0d", i), rq[i].r, (i % 2 == 0) ? r0[i / 2] : r1[i / 2]);
        check_val($sformatf("t2_cyc%0d", i), rq[i].cyc - rq[0].cyc, i);
      end
    end

    // Requester 1 streams 33 back-to-back ops: n*1000/(n+1).
    rq.delete();
    for (int i = 0; i < 33; i++) begin
      req_valid              = 2'b10;
      req_dividend[DW +: DW] = (i + 1) * 1000;
      req_divisor[DW +: DW]  = i + 2;
      #1;
      if (i == 0 || i == 32) check_val($sformatf("t3_gnt%0d", i), req_ready, 2'b10);
      @(negedge clk);
    end
    req_valid = '0;
    check_val("t3_inflmax", inflight, 6'd33);
    repeat (40) @(negedge clk);
    check_val("t3_count", rq.size(), 33);
    check_val("t3_infl0", inflight, 6'd0);
    if (rq.size() == 33) begin
      for (int i = 0; i < 33; i++) begin
        if (rq[i].id !== 1'b1 || rq[i].q !== 32'(((i + 1) * 1000) / (i + 2)) ||
            rq[i].r !== 32'(((i + 1) * 1000) % (i + 2)) || rq[i].cyc != rq[0].cyc + i)
          check_val($sformatf("t3_rsp%0d", i), {rq[i].id, rq[i].q}, {1'b1, 32'(((i + 1) * 1000) / (i + 2))} ^ 64'h8000_0000_0000_0000);
        else
          check_val($sformatf("t3_rsp%0d", i), rq[i].q, 32'(((i + 1) * 1000) / (i + 2)));
      end
    end

    // Reset in the middle of 5 in-flight ops: nothing may come back.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req_valid             = 2'b01;
      req_dividend[0 +: DW] = 32'(i + 10);
      req_divisor[0 +: DW]  = 32'd3;
      @(negedge clk);
    end
    req_valid = '0;
    repeat (10) @(negedge clk);
    check_val("t4_infl5", inflight, 6'd5);
    rst_n     = 1'b0;
    req_valid = 2'b01;
    #1;
    check_val("t4_ready", req_ready, 2'b00);
    check_val("t4_start", div_start, 1'b0);
    check_val("t4_infl", inflight, 6'd0);
    check_val("t4_rspv", rsp_valid, 2'b00);
    repeat (2) @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
    repeat (50) @(negedge clk);
    check_val("t4_norsp", rq.size(), 0);
    check_val("t4_err", err_desync, 1'b0);

    // Divide by zero.
    rq.delete();
    req_valid             = 2'b01;
    req_dividend[0 +: DW] = 32'h1234;
    req_divisor[0 +: DW]  = 32'd0;
    @(negedge clk);
    req_valid = '0;
    repeat (40) @(negedge clk);
    check_val("t5_count", rq.size(), 1);
    if (rq.size() == 1) begin
      check_val("t5_quot", rq[0].q, 32'hFFFF_FFFF);
`ifdef CLAHE_DIV_ZERO_GUARD_EN
      check_val("t5_rem", rq[0].r, 32'd0);
      check_val("t5_dz", rq[0].dz, 1'b1);
`else
      check_val("t5_rem", rq[0].r, 32'h1234);
      check_val("t5_dz", rq[0].dz, 1'b0);
`endif
    end

    // Spurious div_done with an empty tag pipeline.
    rq.delete();
    check_val("t6_err_pre", err_desync, 1'b0);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    check_val("t6_err", err_desync, 1'b1);
    repeat (20) @(negedge clk);
    check_val("t6_sticky", err_desync, 1'b1);
    check_val("t6_norsp", rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
